mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction-fetch and data requests onto a single
// word-addressed RAM port, with a per-access wait timeout and misaligned-fetch
// rejection. All outputs except stall_req are registered.
module mem_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_done,
  output logic        if_err,
  // data port
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_err,
  // RAM port
  output logic        ram_ce,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  // pipeline
  output logic        stall_req
);

  localparam int unsigned WAIT_W = 5;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] IF_BUSY  = 2'd1;
  localparam logic [1:0] MEM_BUSY = 2'd2;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  logic [1:0]        state,      state_n;
  logic              last_grant, last_grant_n;
  logic [WAIT_W-1:0] wait_cnt,   wait_cnt_n;
  logic [31:0]       addr_q,     addr_n;
  logic              ram_ce_n,   ram_we_n;
  logic [31:0]       ram_wdata_n;
  logic [3:0]        ram_sel_n;
  logic [31:0]       if_inst_n,  mem_rdata_n;
  logic              if_done_n,  if_err_n;
  logic              mem_done_n, mem_err_n;

  logic              if_ok, mem_ok, grant_mem, grant_if;
  logic [WAIT_W-1:0] wait_inc;
  logic              wait_expired;

  // Eligibility excludes a requester whose done pulse is still showing
  assign if_ok        = if_req  & ~if_done;
  assign mem_ok       = mem_req & ~mem_done;
  assign grant_mem    = mem_ok & (~if_ok | (last_grant == GRANT_IF));
  assign grant_if     = if_ok & ~grant_mem;
  assign wait_inc     = wait_cnt + WAIT_W'(1);
  assign wait_expired = (wait_inc == WAIT_MAX);

  // RAM word address comes straight from the registered byte address
  assign ram_addr  = addr_q[31:2];

  // Stall while any request is outstanding and not completing this cycle
  assign stall_req = (if_req & ~if_done) | (mem_req & ~mem_done);

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    wait_cnt_n   = wait_cnt;
    addr_n       = addr_q;
    ram_ce_n     = ram_ce;
    ram_we_n     = ram_we;
    ram_wdata_n  = ram_wdata;
    ram_sel_n    = ram_sel;
    if_inst_n    = if_inst;
    mem_rdata_n  = mem_rdata;
    if_done_n    = 1'b0;
    if_err_n     = 1'b0;
    mem_done_n   = 1'b0;
    mem_err_n    = 1'b0;

    case (state)
      IDLE: begin
        if (grant_mem) begin
          state_n      = MEM_BUSY;
          last_grant_n = GRANT_MEM;
          wait_cnt_n   = '0;
          addr_n       = mem_addr;
          ram_ce_n     = 1'b1;
          ram_we_n     = mem_we;
          ram_wdata_n  = mem_wdata;
          ram_sel_n    = mem_sel;
        end else if (grant_if) begin
          state_n      = IF_BUSY;
          last_grant_n = GRANT_IF;
          wait_cnt_n   = '0;
          addr_n       = if_addr;
          // a misaligned fetch never touches the RAM
          ram_ce_n     = (if_addr[1:0] == 2'b00);
          ram_we_n     = 1'b0;
          ram_sel_n    = 4'b1111;
        end
      end

      IF_BUSY: begin
        if (addr_q[1:0] != 2'b00) begin
          state_n   = IDLE;
          ram_ce_n  = 1'b0;
          if_done_n = 1'b1;
          if_err_n  = 1'b1;
          if_inst_n = NOP_INST;
        end else if (ram_ack) begin
          state_n   = IDLE;
          ram_ce_n  = 1'b0;
          if_done_n = 1'b1;
          if_inst_n = {ram_rdata[7:0], ram_rdata[15:8],
                       ram_rdata[23:16], ram_rdata[31:24]};
        end else if (wait_expired) begin
          state_n    = IDLE;
          ram_ce_n   = 1'b0;
          wait_cnt_n = wait_inc;
          if_done_n  = 1'b1;
          if_err_n   = 1'b1;
          if_inst_n  = NOP_INST;
        end else begin
          wait_cnt_n = wait_inc;
        end
      end

      MEM_BUSY: begin
        if (ram_ack) begin
          state_n    = IDLE;
          ram_ce_n   = 1'b0;
          ram_we_n   = 1'b0;
          mem_done_n = 1'b1;
          if (!ram_we) begin
            mem_rdata_n = ram_rdata;
          end
        end else if (wait_expired) begin
          state_n    = IDLE;
          ram_ce_n   = 1'b0;
          ram_we_n   = 1'b0;
          wait_cnt_n = wait_inc;
          mem_done_n = 1'b1;
          mem_err_n  = 1'b1;
        end else begin
          wait_cnt_n = wait_inc;
        end
      end

      default: begin
        state_n  = IDLE;
        ram_ce_n = 1'b0;
        ram_we_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_IF;
      wait_cnt   <= '0;
      addr_q     <= '0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      ram_sel    <= '0;
      if_inst    <= NOP_INST;
      mem_rdata  <= '0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      mem_done   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      wait_cnt   <= wait_cnt_n;
      addr_q     <= addr_n;
      ram_ce     <= ram_ce_n;
      ram_we     <= ram_we_n;
      ram_wdata  <= ram_wdata_n;
      ram_sel    <= ram_sel_n;
      if_inst    <= if_inst_n;
      mem_rdata  <= mem_rdata_n;
      if_done    <= if_done_n;
      if_err     <= if_err_n;
      mem_done   <= mem_done_n;
      mem_err    <= mem_err_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reset, contention, fetch, write, misaligned
// fetch, timeout and reset in the middle of a data access.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_done, if_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_err;
  logic        ram_ce, ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stall_req;

  int n_cmp = 0;
  int n_bad = 0;
  int ce_rises = 0;
  logic ce_prev = 1'b0;

  mem_ctrl #(.TIMEOUT(16), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
    .if_done(if_done), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_err(mem_err),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_sel(ram_sel), .ram_rdata(ram_rdata),
    .ram_ack(ram_ack), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Count RAM accesses started, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_ce && !ce_prev) ce_rises++;
    ce_prev = ram_ce;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_addr = 0; mem_wdata = 0; mem_sel = 0; ram_rdata = 0; ram_ack = 0;
    tick(); tick();
    n_cmp++; if (ram_ce !== 1'b0) begin n_bad++; $display("FAIL rst_ram_ce got %b want 0", ram_ce); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
    n_cmp++; if ({if_done, if_err, mem_done, mem_err} !== 4'b0) begin n_bad++; $display("FAIL rst_done_err got %b want 0000", {if_done, if_err, mem_done, mem_err}); end
    n_cmp++; if (if_inst !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_if_inst got %h want 00000013", if_inst); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_rdata got %h want 0", mem_rdata); end
    n_cmp++; if (ram_sel !== 4'h0) begin n_bad++; $display("FAIL rst_ram_sel got %h want 0", ram_sel); end
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall_req); end
    rst = 1'b0;
    tick();
    // stray ack while idle
    ram_ack = 1'b1; ram_rdata = 32'hFFFF_FFFF;
    tick();
    ram_ack = 1'b0;
    tick();
    n_cmp++; if ({if_done, mem_done, ram_ce} !== 3'b0) begin n_bad++; $display("FAIL idle_ack_ignored got %b want 000", {if_done, mem_done, ram_ce}); end
    n_cmp++; if (if_inst !== 32'h0000_0013) begin n_bad++; $display("FAIL idle_ack_inst got %h want 00000013", if_inst); end
  endtask

  task automatic test_contention;
    int rises0;
    rises0 = ce_rises;
    if_req = 1; if_addr = 32'h0000_0010;
    mem_req = 1; mem_we = 0; mem_addr = 32'h0000_0200; mem_sel = 4'hF;
    tick();  // data wins first contended grant
    n_cmp++; if (ram_ce !== 1'b1 || ram_addr !== 30'h80) begin n_bad++; $display("FAIL cont_first_grant ce=%b addr=%h want 1/080", ram_ce, ram_addr); end
    n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL cont_stall got %b want 1", stall_req); end
    tick();
    ram_ack = 1; ram_rdata = 32'hCAFE_F00D;
    tick();
    ram_ack = 0;
    n_cmp++; if (mem_done !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL cont_mem_done done=%b err=%b rdata=%h want 1/0/cafef00d", mem_done, mem_err, mem_rdata); end
    n_cmp++; if (if_done !== 1'b0 || ram_ce !== 1'b0) begin n_bad++; $display("FAIL cont_gap if_done=%b ce=%b want 0/0", if_done, ram_ce); end
    tick();  // requester drops mem_req after seeing done
    mem_req = 0;
    n_cmp++; if (ram_ce !== 1'b1 || ram_addr !== 30'h4 || ram_sel !== 4'hF || ram_we !== 1'b0) begin n_bad++; $display("FAIL cont_second_grant ce=%b addr=%h sel=%h we=%b want 1/004/f/0", ram_ce, ram_addr, ram_sel, ram_we); end
    ram_ack = 1; ram_rdata = 32'h1122_3344;
    tick();
    ram_ack = 0;
    n_cmp++; if (if_done !== 1'b1 || if_inst !== 32'h4433_2211) begin n_bad++; $display("FAIL cont_if_done done=%b inst=%h want 1/44332211", if_done, if_inst); end
    if_req = 0;
    tick(); tick();
    n_cmp++; if (ce_rises - rises0 !== 2) begin n_bad++; $display("FAIL cont_grant_count got %0d want 2", ce_rises - rises0); end
  endtask

  task automatic test_fetch;
    if_req = 1; if_addr = 32'h0000_0004;
    tick();
    n_cmp++; if (ram_ce !== 1'b1 || ram_addr !== 30'h1 || ram_we !== 1'b0 || ram_sel !== 4'hF) begin n_bad++; $display("FAIL fetch_ram ce=%b addr=%h we=%b sel=%h want 1/001/0/f", ram_ce, ram_addr, ram_we, ram_sel); end
    tick();
    n_cmp++; if (if_done !== 1'b0 || ram_ce !== 1'b1) begin n_bad++; $display("FAIL fetch_wait done=%b ce=%b want 0/1", if_done, ram_ce); end
    ram_ack = 1; ram_rdata = 32'h9300_1000;
    tick();
    ram_ack = 0;
    n_cmp++; if (if_done !== 1'b1 || if_err !== 1'b0 || if_inst !== 32'h0010_0093) begin n_bad++; $display("FAIL fetch_done done=%b err=%b inst=%h want 1/0/00100093", if_done, if_err, if_inst); end
    n_cmp++; if (stall_req !== 1'b0 || ram_ce !== 1'b0) begin n_bad++; $display("FAIL fetch_stall stall=%b ce=%b want 0/0", stall_req, ram_ce); end
    if_req = 0;
    tick();
    n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse got %b want 0", if_done); end
  endtask

  task automatic test_write;
    mem_req = 1; mem_we = 1; mem_addr = 32'h0000_0100; mem_sel = 4'b0011; mem_wdata = 32'hDEAD_BEEF;
    tick();
    n_cmp++; if (ram_ce !== 1'b1 || ram_addr !== 30'h40 || ram_we !== 1'b1 || ram_sel !== 4'b0011 || ram_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_ram ce=%b addr=%h we=%b sel=%h wd=%h want 1/040/1/3/deadbeef", ram_ce, ram_addr, ram_we, ram_sel, ram_wdata); end
    tick();
    n_cmp++; if (ram_we !== 1'b1 || ram_sel !== 4'b0011 || mem_done !== 1'b0) begin n_bad++; $display("FAIL wr_hold we=%b sel=%h done=%b want 1/3/0", ram_we, ram_sel, mem_done); end
    ram_ack = 1; ram_rdata = 32'h5555_AAAA;
    tick();
    ram_ack = 0;
    n_cmp++; if (mem_done !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL wr_done done=%b err=%b rdata=%h want 1/0/cafef00d", mem_done, mem_err, mem_rdata); end
    tick();  // mem_req still high during done: must not be re-granted
    n_cmp++; if (ram_ce !== 1'b0 || mem_done !== 1'b0) begin n_bad++; $display("FAIL wr_no_regrant ce=%b done=%b want 0/0", ram_ce, mem_done); end
    mem_req = 0; mem_we = 0;
    tick();
  endtask

  task automatic test_misaligned;
    int rises0;
    rises0 = ce_rises;
    if_req = 1; if_addr = 32'h0000_0006;
    tick();
    n_cmp++; if (ram_ce !== 1'b0 || if_done !== 1'b0) begin n_bad++; $display("FAIL mis_grant ce=%b done=%b want 0/0", ram_ce, if_done); end
    tick();
    n_cmp++; if (if_done !== 1'b1 || if_err !== 1'b1 || if_inst !== 32'h0000_0013) begin n_bad++; $display("FAIL mis_done done=%b err=%b inst=%h want 1/1/00000013", if_done, if_err, if_inst); end
    if_req = 0;
    tick();
    n_cmp++; if (if_err !== 1'b0 || ce_rises !== rises0) begin n_bad++; $display("FAIL mis_no_ce err=%b rises=%0d want 0/%0d", if_err, ce_rises, rises0); end
  endtask

  task automatic test_timeout;
    int ce_cycles;
    bit seen;
    ce_cycles = 0; seen = 0;
    if_req = 1; if_addr = 32'h0000_0008;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if_done) begin seen = 1; break; end
      if (ram_ce) ce_cycles++;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL to_done_seen got 0 want 1"); end
    n_cmp++; if (ce_cycles !== 16) begin n_bad++; $display("FAIL to_ce_cycles got %0d want 16", ce_cycles); end
    n_cmp++; if (if_err !== 1'b1 || if_inst !== 32'h0000_0013 || ram_ce !== 1'b0) begin n_bad++; $display("FAIL to_abort err=%b inst=%h ce=%b want 1/00000013/0", if_err, if_inst, ram_ce); end
    if_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_access;
    mem_req = 1; mem_we = 0; mem_addr = 32'h0000_0300; mem_sel = 4'hF;
    tick();
    n_cmp++; if (ram_ce !== 1'b1) begin n_bad++; $display("FAIL rma_busy ce=%b want 1", ram_ce); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ram_ce !== 1'b0) begin n_bad++; $display("FAIL rma_ce_async got %b want 0", ram_ce); end
    mem_req = 0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (mem_done !== 1'b0 || ram_ce !== 1'b0 || mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rma_no_done done=%b ce=%b rdata=%h want 0/0/0", mem_done, ram_ce, mem_rdata); end
    mem_req = 1; mem_addr = 32'h0000_0044;
    tick();
    n_cmp++; if (ram_ce !== 1'b1 || ram_addr !== 30'h11) begin n_bad++; $display("FAIL rma_fresh_grant ce=%b addr=%h want 1/011", ram_ce, ram_addr); end
    ram_ack = 1; ram_rdata = 32'h1234_5678;
    tick();
    ram_ack = 0;
    n_cmp++; if (mem_done !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rma_fresh_done done=%b err=%b rdata=%h want 1/0/12345678", mem_done, mem_err, mem_rdata); end
    mem_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fetch();
    test_write();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
